// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and control-word bit positions for the ALU microsequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    EXEC  = 2'd3
  } seq_state_t;

  // Store-request bits sit at the bottom of the control word; the LAST flag rides just above it.
  localparam int CW_STORE_MEM = 1;
  localparam int CW_STORE_STK = 0;
  localparam int CW_LAST      = 55;

endpackage

// File: rtl/alu_microsequencer_if.sv
// rtl/alu_microsequencer_if.sv - control-store read bus and decoder issue bus of the ALU microsequencer
interface alu_microsequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CW_W   = 55
) ();

  logic              cs_rd_en;
  logic [ADDR_W-1:0] cs_addr;
  logic [CW_W:0]     cs_rd_data;
  logic              mem_ready;
  logic              stk_ready;
  logic [CW_W-1:0]   control_word;
  logic              word_valid;

  modport master (
    output cs_rd_en,
    output cs_addr,
    input  cs_rd_data,
    input  mem_ready,
    input  stk_ready,
    output control_word,
    output word_valid
  );

  modport slave (
    input  cs_rd_en,
    input  cs_addr,
    output cs_rd_data,
    output mem_ready,
    output stk_ready,
    input  control_word,
    input  word_valid
  );

endinterface

// File: rtl/alu_store_tracker.sv
// rtl/alu_store_tracker.sv - pending memory/stack store flags for the word currently being executed
module alu_store_tracker (
  input  logic clk,
  input  logic reset_n,
  input  logic drop,
  input  logic load,
  input  logic load_mem,
  input  logic load_stk,
  input  logic mem_ready,
  input  logic stk_ready,
  output logic all_clear
);

  logic pend_mem;
  logic pend_stk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_mem <= 1'b0;
      pend_stk <= 1'b0;
    end else if (drop) begin
      pend_mem <= 1'b0;
      pend_stk <= 1'b0;
    end else if (load) begin
      pend_mem <= load_mem;
      pend_stk <= load_stk;
    end else begin
      if (mem_ready) pend_mem <= 1'b0;
      if (stk_ready) pend_stk <= 1'b0;
    end
  end

  // A ready arriving this cycle already counts, so the word may retire in the same cycle.
  assign all_clear = (!pend_mem || mem_ready) && (!pend_stk || stk_ready);

endmodule

// File: rtl/alu_microsequencer.sv
// rtl/alu_microsequencer.sv - walks control-store microcode and issues one ALU control word at a time
module alu_microsequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CW_W    = CW_LAST,
  parameter int MAX_LEN = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic                 abort,
  alu_microsequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] upc;
  logic              rd_en;
  logic [CW_W-1:0]   word;
  logic              word_valid;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              all_clear;

  assign count_next = count + 1'b1;

  alu_store_tracker u_store_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .drop      (abort),
    .load      (state == ISSUE),
    .load_mem  (bus.cs_rd_data[CW_STORE_MEM]),
    .load_stk  (bus.cs_rd_data[CW_STORE_STK]),
    .mem_ready (bus.mem_ready),
    .stk_ready (bus.stk_ready),
    .all_clear (all_clear)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      upc        <= '0;
      rd_en      <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      last       <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        // Abort drops the running word without touching the sticky error flag.
        state      <= IDLE;
        upc        <= '0;
        rd_en      <= 1'b0;
        word       <= '0;
        word_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              upc   <= start_addr;
              rd_en <= 1'b1;
              count <= '0;
              error <= 1'b0;
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
          FETCH: begin
            rd_en <= 1'b0;
            state <= ISSUE;
          end
          ISSUE: begin
            word       <= bus.cs_rd_data[CW_W-1:0];
            last       <= bus.cs_rd_data[CW_W];
            word_valid <= 1'b1;
            state      <= EXEC;
          end
          EXEC: begin
            if (all_clear) begin
              word_valid <= 1'b0;
              word       <= '0;
              count      <= count_next;
              if (last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else if (count_next == CNT_W'(MAX_LEN)) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                upc   <= upc + 1'b1;
                rd_en <= 1'b1;
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cs_rd_en     = rd_en;
  assign bus.cs_addr      = upc;
  assign bus.control_word = word;
  assign bus.word_valid   = word_valid;

endmodule

// File: tb/tb_alu_microsequencer.sv
// tb/tb_alu_microsequencer.sv - directed self-checking bench for alu_microsequencer
module tb_alu_microsequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] start_addr;
  logic       abort;
  logic       busy;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;

  logic [55:0] rom [256];

  alu_microsequencer_if #(.ADDR_W(8), .CW_W(55)) bus ();

  alu_microsequencer #(.ADDR_W(8), .CW_W(55), .MAX_LEN(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cs_rd_en) bus.cs_rd_data <= rom[bus.cs_addr];
  end

  function automatic logic [55:0] mk(input bit lst, input bit sm, input bit sk, input logic [52:0] p);
    return {lst, p, sm, sk};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [55:0] wa, wb, wc, wd, we, wf, wg;
  int n_words;
  int n_done;
  logic prev_valid;

  initial begin
    wa = mk(1'b0, 1'b0, 1'b0, 53'h0_1234_5678_9ABC);
    wb = mk(1'b0, 1'b0, 1'b0, 53'h1_5555_AAAA_5555);
    wc = mk(1'b1, 1'b0, 1'b0, 53'h0_0F0F_F0F0_0F0F);
    wd = mk(1'b1, 1'b1, 1'b1, 53'h1_DEAD_BEEF_0001);
    we = mk(1'b0, 1'b0, 1'b0, 53'h0_0000_0000_00EE);
    wf = mk(1'b1, 1'b0, 1'b0, 53'h0_0000_0000_00FF);
    wg = mk(1'b1, 1'b1, 1'b1, 53'h0_0000_CAFE_0000);
    rom[8'h10] = wa; rom[8'h11] = wb; rom[8'h12] = wc;
    rom[8'h20] = wd; rom[8'h21] = wd;
    rom[8'hFF] = we; rom[8'h00] = wf;
    rom[8'h30] = wg;
    for (int i = 8'h40; i < 8'h48; i++) rom[i] = mk(1'b0, 1'b0, 1'b0, 53'(i));

    // 1. reset with start held high
    reset_n = 1'b0; start = 1'b1; start_addr = 8'h10; abort = 1'b0;
    bus.mem_ready = 1'b0; bus.stk_ready = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {busy, done, error, bus.cs_rd_en, bus.word_valid, bus.cs_addr},
        {5'b0, 8'h00});
    chk("rst_cw", 64'(bus.control_word), 64'h0);
    reset_n = 1'b1; start = 1'b0;
    step();
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_fetch", 64'(bus.cs_rd_en), 64'h0);

    // 2. three-word sequence, LAST on 0x12
    start_addr = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("seq_first_fetch", {bus.cs_rd_en, busy, bus.cs_addr}, {2'b11, 8'h10});
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("seq_valid_c%0d", k), 64'(bus.word_valid), 64'(k == 2 || k == 5 || k == 8));
      chk($sformatf("seq_done_c%0d", k), 64'(done), 64'(k == 9));
      if (k == 2) chk("seq_word_a", 64'(bus.control_word), 64'(wa[54:0]));
      if (k == 5) chk("seq_word_b", 64'(bus.control_word), 64'(wb[54:0]));
      if (k == 8) chk("seq_word_c", 64'(bus.control_word), 64'(wc[54:0]));
      if (k == 3) chk("seq_fetch_11", {bus.cs_rd_en, bus.cs_addr}, {1'b1, 8'h11});
      if (k == 6) chk("seq_fetch_12", {bus.cs_rd_en, bus.cs_addr}, {1'b1, 8'h12});
      if (k == 9) chk("seq_idle_busy", 64'(busy), 64'h0);
    end

    // 3a. both stores; stk_ready at EXEC+2, mem_ready at EXEC+4
    start_addr = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    for (int n = 0; n <= 6; n++) begin
      chk($sformatf("st_valid_e%0d", n), 64'(bus.word_valid), 64'(n <= 4));
      if (n <= 4) chk($sformatf("st_word_e%0d", n), 64'(bus.control_word), 64'(wd[54:0]));
      chk($sformatf("st_done_e%0d", n), 64'(done), 64'(n == 5));
      bus.stk_ready = (n == 2);
      bus.mem_ready = (n == 4);
      step();
      bus.stk_ready = 1'b0; bus.mem_ready = 1'b0;
    end

    // 3b. mem_ready at EXEC+0 counts, stk_ready at EXEC+2 retires the word
    start_addr = 8'h21; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    for (int n = 0; n <= 4; n++) begin
      chk($sformatf("st0_valid_e%0d", n), 64'(bus.word_valid), 64'(n <= 2));
      chk($sformatf("st0_done_e%0d", n), 64'(done), 64'(n == 3));
      bus.mem_ready = (n == 0);
      bus.stk_ready = (n == 2);
      step();
      bus.stk_ready = 1'b0; bus.mem_ready = 1'b0;
    end

    // 4. address wrap from 0xFF to 0x00
    start_addr = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    chk("wrap_first", {bus.cs_rd_en, bus.cs_addr}, {1'b1, 8'hFF});
    step(); step(); step();
    chk("wrap_second", {bus.cs_rd_en, bus.cs_addr}, {1'b1, 8'h00});
    step(); step();
    chk("wrap_word_f", {bus.word_valid, bus.control_word}, {1'b1, wf[54:0]});
    step();
    chk("wrap_done", 64'(done), 64'h1);

    // 5. MAX_LEN=4 with no LAST in the ROM
    start_addr = 8'h40; start = 1'b1;
    step();
    start = 1'b0;
    n_words = 0; n_done = 0; prev_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (bus.word_valid && !prev_valid) n_words++;
      if (done) n_done++;
      prev_valid = bus.word_valid;
    end
    chk("maxlen_words", 64'(n_words), 64'd4);
    chk("maxlen_no_done", 64'(n_done), 64'd0);
    chk("maxlen_error", {error, busy, bus.cs_rd_en}, {1'b1, 2'b00});
    start_addr = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_clears_error", {error, busy}, {1'b0, 1'b1});
    repeat (10) step();
    chk("restart_idle", 64'(busy), 64'h0);

    // 6. abort in EXEC with stores pending; start while busy ignored
    start_addr = 8'h30; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("abort_exec_word", {bus.word_valid, bus.control_word}, {1'b1, wg[54:0]});
    start_addr = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ignored", {bus.word_valid, bus.cs_rd_en, bus.cs_addr}, {2'b10, 8'h30});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {busy, bus.word_valid, bus.cs_rd_en, done}, 4'b0000);
    chk("abort_cw", 64'(bus.control_word), 64'h0);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done || busy) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_error_kept", 64'(error), 64'h0);
    start_addr = 8'h10; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_same", {busy, bus.cs_rd_en}, 2'b00);
    step();
    chk("start_abort_stay", {busy, bus.cs_rd_en}, 2'b00);

    // 7. asynchronous reset mid-word
    start_addr = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("areset_pre", 64'(bus.word_valid), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid_drop", {bus.word_valid, busy, bus.cs_rd_en}, 3'b000);
    chk("areset_cw", 64'(bus.control_word), 64'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("areset_after", 64'(busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
